// File: rtl/rom_load_pkg.sv
// Shared types and default region map for the ROM download sequencer.
// Region i starts where region i-1 ends; program ROM sits at address 0.
package rom_load_pkg;

    localparam int PROG_SIZE_DEF   = 8192;
    localparam int VEC_SIZE_DEF    = 4096;
    localparam int PROM_SIZE_DEF   = 256;
    localparam int HOLD_CYCLES_DEF = 1024;

    localparam int PROG_BASE_DEF = 0;
    localparam int VEC_BASE_DEF  = PROG_BASE_DEF + PROG_SIZE_DEF;
    localparam int PROM_BASE_DEF = VEC_BASE_DEF + VEC_SIZE_DEF;
    localparam int IMG_END_DEF   = PROM_BASE_DEF + PROM_SIZE_DEF;

    localparam int ADDR_W = 16;
    localparam int REL_W  = 13;
    localparam int CNT_W  = 17;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_e;
    typedef enum logic [1:0] {R_PROG, R_VEC, R_PROM, R_NONE} region_e;

    typedef struct packed {
        region_e           region;
        logic [REL_W-1:0]  rel;
    } dec_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ioctl address -> ROM region select and region-relative address.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int PROG_SIZE = PROG_SIZE_DEF,
    parameter int VEC_SIZE  = VEC_SIZE_DEF,
    parameter int PROM_SIZE = PROM_SIZE_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output dec_t              dec
);

    localparam logic [CNT_W-1:0] VEC_BASE  = CNT_W'(PROG_SIZE);
    localparam logic [CNT_W-1:0] PROM_BASE = CNT_W'(PROG_SIZE + VEC_SIZE);
    localparam logic [CNT_W-1:0] IMG_END   = CNT_W'(PROG_SIZE + VEC_SIZE + PROM_SIZE);

    logic [CNT_W-1:0] a;

    always_comb begin
        a          = {1'b0, addr};
        dec.region = R_NONE;
        dec.rel    = '0;
        if (a < VEC_BASE) begin
            dec.region = R_PROG;
            dec.rel    = REL_W'(a);
        end else if (a < PROM_BASE) begin
            dec.region = R_VEC;
            dec.rel    = REL_W'(a - VEC_BASE);
        end else if (a < IMG_END) begin
            dec.region = R_PROM;
            dec.rel    = REL_W'(a - PROM_BASE);
        end
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// Routes ioctl download bytes to the game ROMs, checksums each region and
// holds the core in reset until a download has finished and settled.
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int PROG_SIZE   = PROG_SIZE_DEF,
    parameter int VEC_SIZE    = VEC_SIZE_DEF,
    parameter int PROM_SIZE   = PROM_SIZE_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic              clk_25,
    input  logic              RESET_L,
    input  logic              dn_download,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [7:0]        dn_data,
    output logic [REL_W-1:0]  rom_addr,
    output logic [7:0]        rom_data,
    output logic              prog_we,
    output logic              vec_we,
    output logic              prom_we,
    output logic              core_reset_l,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        csum_prog,
    output logic [7:0]        csum_vec,
    output logic [7:0]        csum_prom
);

    localparam logic [CNT_W-1:0] IMG_BYTES = CNT_W'(PROG_SIZE + VEC_SIZE + PROM_SIZE);
    localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    dec_t               dec;
    logic               wr_ok, start, fall, hold_done;

    rom_region_decode #(
        .PROG_SIZE (PROG_SIZE),
        .VEC_SIZE  (VEC_SIZE),
        .PROM_SIZE (PROM_SIZE)
    ) u_dec (
        .addr (dn_addr),
        .dec  (dec)
    );

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        fall      = 1'b0;
        hold_done = 1'b0;
        wr_ok     = (state_q == LOAD) && dn_download && dn_wr;
        case (state_q)
            IDLE, RUN: if (dn_download) begin
                start   = 1'b1;
                state_d = LOAD;
            end
            LOAD: if (!dn_download) begin
                fall    = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (dn_download) begin
                start   = 1'b1;
                state_d = LOAD;
            end else if (hold_cnt == HOLD_LAST) begin
                hold_done = 1'b1;
                state_d   = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (!RESET_L) begin
            state_q      <= IDLE;
            rom_addr     <= '0;
            rom_data     <= '0;
            prog_we      <= 1'b0;
            vec_we       <= 1'b0;
            prom_we      <= 1'b0;
            core_reset_l <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            csum_prog    <= '0;
            csum_vec     <= '0;
            csum_prom    <= '0;
            byte_cnt     <= '0;
            hold_cnt     <= '0;
        end else begin
            state_q      <= state_d;
            prog_we      <= wr_ok && (dec.region == R_PROG);
            vec_we       <= wr_ok && (dec.region == R_VEC);
            prom_we      <= wr_ok && (dec.region == R_PROM);
            core_reset_l <= (state_d == RUN);

            if (wr_ok && dec.region != R_NONE) begin
                rom_addr <= dec.rel;
                rom_data <= dn_data;
            end

            if (start) begin
                csum_prog <= '0;
                csum_vec  <= '0;
                csum_prom <= '0;
                byte_cnt  <= '0;
                load_err  <= 1'b0;
                load_done <= 1'b0;
            end else if (wr_ok) begin
                // Out-of-range bytes still count toward the image length.
                if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
                case (dec.region)
                    R_PROG:  csum_prog <= csum_prog + dn_data;
                    R_VEC:   csum_vec  <= csum_vec + dn_data;
                    R_PROM:  csum_prom <= csum_prom + dn_data;
                    default: load_err  <= 1'b1;
                endcase
            end

            if (fall && byte_cnt < IMG_BYTES) load_err <= 1'b1;
            if (hold_done) load_done <= 1'b1;

            if (state_q == HOLD && state_d == HOLD) hold_cnt <= hold_cnt + 1'b1;
            else                                     hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer: spec-level model checked every cycle
// plus literal expectations for pulse counts, checksums and release timing.
module tb_rom_load_sequencer;

    localparam int PROG  = 8192;
    localparam int VEC   = 4096;
    localparam int PROM  = 256;
    localparam int TOTAL = PROG + VEC + PROM;
    localparam int HOLDC = 16;

    localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3;

    logic        clk_25 = 1'b0;
    logic        RESET_L = 1'b0;
    logic        dn_download = 1'b0;
    logic        dn_wr = 1'b0;
    logic [15:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic        prog_we, vec_we, prom_we, core_reset_l, load_done, load_err;
    logic [7:0]  csum_prog, csum_vec, csum_prom;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    int n_prog, n_vec, n_prom;
    int rise;

    // model state
    int m_phase, m_addr, m_data, m_cp, m_cv, m_cr, m_bytes, m_hold, ma, md;
    bit m_pw, m_vw, m_rw, m_core, m_done, m_err;

    rom_load_sequencer #(
        .PROG_SIZE   (PROG),
        .VEC_SIZE    (VEC),
        .PROM_SIZE   (PROM),
        .HOLD_CYCLES (HOLDC)
    ) dut (
        .clk_25       (clk_25),
        .RESET_L      (RESET_L),
        .dn_download  (dn_download),
        .dn_wr        (dn_wr),
        .dn_addr      (dn_addr),
        .dn_data      (dn_data),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .prog_we      (prog_we),
        .vec_we       (vec_we),
        .prom_we      (prom_we),
        .core_reset_l (core_reset_l),
        .load_done    (load_done),
        .load_err     (load_err),
        .csum_prog    (csum_prog),
        .csum_vec     (csum_vec),
        .csum_prom    (csum_prom)
    );

    always #20 clk_25 = ~clk_25;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks what the outputs must be after each edge.
    always @(posedge clk_25) begin
        if (!RESET_L) begin
            m_phase = P_IDLE;
            m_pw = 0; m_vw = 0; m_rw = 0;
            m_addr = 0; m_data = 0;
            m_core = 0; m_done = 0; m_err = 0;
            m_cp = 0; m_cv = 0; m_cr = 0;
            m_bytes = 0; m_hold = 0;
            chk_en = 1;
        end else begin
            m_pw = 0; m_vw = 0; m_rw = 0;
            if (m_phase == P_LOAD && dn_download && dn_wr) begin
                ma = int'(dn_addr);
                md = int'(dn_data);
                if (ma < PROG) begin
                    m_pw = 1; m_addr = ma; m_data = md; m_cp = (m_cp + md) % 256;
                end else if (ma < PROG + VEC) begin
                    m_vw = 1; m_addr = ma - PROG; m_data = md; m_cv = (m_cv + md) % 256;
                end else if (ma < TOTAL) begin
                    m_rw = 1; m_addr = ma - PROG - VEC; m_data = md; m_cr = (m_cr + md) % 256;
                end else begin
                    m_err = 1;
                end
                if (m_bytes < 131071) m_bytes++;
            end
            if (m_phase != P_LOAD && dn_download) begin
                m_phase = P_LOAD;
                m_cp = 0; m_cv = 0; m_cr = 0;
                m_bytes = 0; m_err = 0; m_done = 0;
            end else if (m_phase == P_LOAD && !dn_download) begin
                m_phase = P_HOLD;
                m_hold = 0;
                if (m_bytes < TOTAL) m_err = 1;
            end else if (m_phase == P_HOLD) begin
                if (m_hold == HOLDC - 1) begin
                    m_phase = P_RUN;
                    m_done = 1;
                end else begin
                    m_hold++;
                end
            end
            m_core = (m_phase == P_RUN);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk_25) begin
        if (chk_en) begin
            chk("prog_we", prog_we, m_pw);
            chk("vec_we", vec_we, m_vw);
            chk("prom_we", prom_we, m_rw);
            chk("core_reset_l", core_reset_l, m_core);
            chk("load_done", load_done, m_done);
            chk("load_err", load_err, m_err);
            chk("csum_prog", csum_prog, m_cp);
            chk("csum_vec", csum_vec, m_cv);
            chk("csum_prom", csum_prom, m_cr);
            if (m_pw || m_vw || m_rw) begin
                chk("rom_addr", rom_addr, m_addr);
                chk("rom_data", rom_data, m_data);
            end
            n_prog += int'(prog_we);
            n_vec  += int'(vec_we);
            n_prom += int'(prom_we);
        end
    end

    task automatic tick;
        @(posedge clk_25);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        tick();
    endtask

    task automatic start_dl;
        dn_download = 1'b1;
        tick();
    endtask

    // Drop download and count edges after the sampling edge until release.
    task automatic end_dl(output int n);
        dn_wr       = 1'b0;
        dn_download = 1'b0;
        tick();
        n = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (core_reset_l === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic full_image(output int n);
        n_prog = 0; n_vec = 0; n_prom = 0;
        start_dl();
        for (int i = 0; i < TOTAL; i++) wr(16'(i), 8'(i));
        end_dl(n);
    endtask

    initial begin
        RESET_L = 1'b0;
        repeat (3) tick();
        RESET_L = 1'b1;
        repeat (100) tick();
        chk("idle_core_reset_l", core_reset_l, 0);
        chk("idle_load_done", load_done, 0);
        chk("idle_we", {prog_we, vec_we, prom_we}, 0);
        chk("idle_csums", {csum_prog, csum_vec, csum_prom}, 0);

        // full image, byte = addr[7:0]
        full_image(rise);
        chk("full_rise_delay", rise, 16);
        chk("full_prog_pulses", n_prog, 8192);
        chk("full_vec_pulses", n_vec, 4096);
        chk("full_prom_pulses", n_prom, 256);
        chk("full_csum_prog", csum_prog, 8'h00);
        chk("full_csum_vec", csum_vec, 8'h00);
        chk("full_csum_prom", csum_prom, 8'h80);
        chk("full_load_done", load_done, 1);
        chk("full_load_err", load_err, 0);

        // single vector write then an out-of-range write
        start_dl();
        chk("restart_core_low", core_reset_l, 0);
        chk("restart_done_clr", load_done, 0);
        wr(16'h2005, 8'hA5);
        chk("vec_we_2005", {prog_we, vec_we, prom_we}, 3'b010);
        chk("vec_addr_2005", rom_addr, 13'h0005);
        chk("vec_data_2005", rom_data, 8'hA5);
        chk("vec_csum_2005", csum_vec, 8'hA5);
        wr(16'h3100, 8'h77);
        chk("oor_no_we", {prog_we, vec_we, prom_we}, 3'b000);
        chk("oor_load_err", load_err, 1);
        chk("oor_csum_vec", csum_vec, 8'hA5);
        end_dl(rise);
        chk("oor_rise_delay", rise, 16);

        // short download of 100 bytes
        start_dl();
        chk("short_err_clr", load_err, 0);
        for (int i = 0; i < 100; i++) wr(16'(i), 8'h03);
        chk("short_csum_prog", csum_prog, 8'h2C);
        end_dl(rise);
        chk("short_rise_delay", rise, 16);
        chk("short_load_err", load_err, 1);
        chk("short_load_done", load_done, 1);

        // re-download 5 cycles into HOLD
        start_dl();
        for (int i = 0; i < 10; i++) wr(16'(i), 8'h11);
        dn_wr = 1'b0;
        dn_download = 1'b0;
        repeat (6) tick();
        chk("hold_core_low", core_reset_l, 0);
        dn_download = 1'b1;
        tick();
        chk("rehold_csums_clr", {csum_prog, csum_vec, csum_prom}, 0);
        chk("rehold_core_low", core_reset_l, 0);
        for (int i = 0; i < 10; i++) wr(16'(PROG + i), 8'h22);
        end_dl(rise);
        chk("rehold_rise_delay", rise, 16);
        chk("rehold_csum_vec", csum_vec, 8'h54);

        // reset pulse in the middle of a load
        start_dl();
        for (int i = 0; i < 50; i++) wr(16'(i), 8'h5A);
        RESET_L = 1'b0;
        tick();
        chk("rst_we", {prog_we, vec_we, prom_we}, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_core_low", core_reset_l, 0);
        RESET_L = 1'b1;
        dn_wr = 1'b0;
        dn_download = 1'b0;
        repeat (2) tick();
        full_image(rise);
        chk("rst_full_rise_delay", rise, 16);
        chk("rst_full_prog_pulses", n_prog, 8192);
        chk("rst_full_load_done", load_done, 1);
        chk("rst_full_load_err", load_err, 0);
        chk("rst_full_csum_prom", csum_prom, 8'h80);

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
